// File: rtl/sysid_check_seq.sv
// Boot-time system-ID/timestamp check sequencer (Avalon-MM read master).
// Optional: define SYSID_CHECK_AUTOSTART_EN to run once after every reset.
module sysid_check_seq #(
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] EXPECTED_TS    = 32'd1417465795,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter int          MAX_RETRIES    = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        error_timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [WW-1:0] WAIT_MAX  = WW'(TIMEOUT_CYCLES);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

    typedef enum logic [2:0] {
        IDLE, RD_ID, RD_TS, GAP, CHECK, DONE
    } state_t;

    state_t        state, state_nx;
    logic [WW-1:0] wait_cnt, wait_nx;
    logic [RW-1:0] retry_cnt, retry_nx;
    logic          addr_nx, id_ok_nx, ts_ok_nx, err_nx;
    logic [31:0]   id_nx, ts_nx;
    logic          go;

`ifdef SYSID_CHECK_AUTOSTART_EN
    logic auto_pend;

    // One-shot: high only in the first cycle after reset releases.
    always_ff @(posedge clock) begin
        auto_pend <= reset;
    end

    assign go = start | auto_pend;
`else
    assign go = start;
`endif

    assign avm_read = (state == RD_ID) || (state == RD_TS);
    assign busy     = avm_read || (state == GAP) || (state == CHECK);
    assign done     = (state == DONE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            retry_cnt     <= '0;
            avm_address   <= 1'b0;
            id_value      <= '0;
            ts_value      <= '0;
            id_ok         <= 1'b0;
            ts_ok         <= 1'b0;
            error_timeout <= 1'b0;
        end else begin
            state         <= state_nx;
            wait_cnt      <= wait_nx;
            retry_cnt     <= retry_nx;
            avm_address   <= addr_nx;
            id_value      <= id_nx;
            ts_value      <= ts_nx;
            id_ok         <= id_ok_nx;
            ts_ok         <= ts_ok_nx;
            error_timeout <= err_nx;
        end
    end

    always_comb begin
        state_nx = state;
        wait_nx  = wait_cnt;
        retry_nx = retry_cnt;
        addr_nx  = avm_address;
        id_nx    = id_value;
        ts_nx    = ts_value;
        id_ok_nx = id_ok;
        ts_ok_nx = ts_ok;
        err_nx   = error_timeout;
        unique case (state)
            IDLE, DONE: begin
                if (go) begin
                    state_nx = RD_ID;
                    addr_nx  = 1'b0;
                    wait_nx  = '0;
                    retry_nx = '0;
                    id_ok_nx = 1'b0;
                    ts_ok_nx = 1'b0;
                    err_nx   = 1'b0;
                end
            end
            RD_ID, RD_TS: begin
                // Data accepted on the limit cycle beats the timeout.
                if (!avm_waitrequest) begin
                    wait_nx  = '0;
                    retry_nx = '0;
                    if (state == RD_ID) begin
                        id_nx    = avm_readdata;
                        addr_nx  = 1'b1;
                        state_nx = RD_TS;
                    end else begin
                        ts_nx    = avm_readdata;
                        state_nx = CHECK;
                    end
                end else if (wait_cnt == WAIT_MAX) begin
                    state_nx = GAP;
                end else begin
                    wait_nx = wait_cnt + 1'b1;
                end
            end
            GAP: begin
                if (retry_cnt == RETRY_MAX) begin
                    state_nx = DONE;
                    err_nx   = 1'b1;
                    id_ok_nx = 1'b0;
                    ts_ok_nx = 1'b0;
                end else begin
                    retry_nx = retry_cnt + 1'b1;
                    wait_nx  = '0;
                    state_nx = avm_address ? RD_TS : RD_ID;
                end
            end
            CHECK: begin
                id_ok_nx = (id_value == EXPECTED_ID);
                ts_ok_nx = (ts_value == EXPECTED_TS);
                state_nx = DONE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule
